multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath; successor to the single-cycle decoder.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath
//  enables and muxes each cycle. Honours a memory-ready handshake so FETCH and the MEM states
//  can wait on slow memory. Supports R-type, lw, sw and beq; j and addi are optional.
// PARAMETERS
//  ALU_OP_W    2  width of alu_op to ALU control (>=2; upper bits zero-extended)
//  WAIT_MEM    1  1: memory states hold until mem_ready; 0: mem_ready treated as always 1
//  ENABLE_J    1  1: decode j (000010); 0: j is illegal
//  ENABLE_ADDI 1  1: decode addi (001000); 0: addi is illegal
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         reset, asynchronous, active-high
//  opcode        in   6         instr[31:26] from the IR; sampled only in DECODE
//  mem_ready     in   1         memory completed access this cycle
//  pc_write      out  1         unconditional PC load
//  pc_write_cond out  1         PC load if alu zero (beq)
//  i_or_d        out  1         memory address: PC(0), ALUOut(1)
//  mem_read      out  1         memory read request
//  mem_write     out  1         memory write request
//  ir_write      out  1         load IR
//  reg_dst       out  1         write reg: rt(0), rd(1)
//  mem_to_reg    out  1         write data: ALUOut(0), MDR(1)
//  reg_write     out  1         register file write enable
//  alu_src_a     out  1         ALU A: PC(0), A reg(1)
//  alu_src_b     out  2         ALU B: B(0), 4(1), sext imm(2), sext imm<<2(3)
//  alu_op        out  ALU_OP_W  00 add, 01 sub, 10 funct-decoded
//  pc_source     out  2         next PC: ALU(0), ALUOut(1), jump target(2)
//  illegal_op    out  1         1-cycle pulse: unsupported opcode decoded
//  state         out  4         current state encoding (debug/verification)
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MADDR=2 MREAD=3 MWB=4 MWRITE=5 EXEC=6 RWB=7 BRANCH=8 JUMP=9
//    AEXEC=10 AWB=11. Encodings 12-15 are unreachable; if entered, next state is FETCH.
//  - rst high: state<=FETCH asynchronously; all outputs 0 while rst high (overrides decode).
//  - Outputs are Moore functions of state, except signals qualified by mem_ready (below).
//  - FETCH: mem_read=1, alu_src_b=1, alu_op=00, pc_source=0.
//    ir_write=pc_write=mem_ready. Goes to DECODE on mem_ready, else holds.
//  - DECODE: alu_src_b=3, alu_op=00 (branch target precompute). Next state by opcode:
//    000000->EXEC; 100011/101011->MADDR; 000100->BRANCH;
//    000010->JUMP if ENABLE_J; 001000->AEXEC if ENABLE_ADDI.
//    Any other opcode: illegal_op=1 this cycle, next state FETCH, no writes.
//  - MADDR: alu_src_a=1, alu_src_b=2, alu_op=00. Next MREAD (lw) or MWRITE (sw),
//    using opcode latched in DECODE.
//  - MREAD: mem_read=1, i_or_d=1; holds until mem_ready, then MWB.
//  - MWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
//  - MWRITE: mem_write=1, i_or_d=1; holds until mem_ready, then FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=0, alu_op=10; then RWB.
//  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_write_cond=1, pc_source=1; then FETCH.
//  - JUMP: pc_write=1, pc_source=2; then FETCH.
//  - AEXEC: alu_src_a=1, alu_src_b=2, alu_op=00; then AWB.
//  - AWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
//  - Unlisted outputs are 0 in every state.
//  - The opcode latch captures opcode only in DECODE; later opcode changes are ignored.
//  - WAIT_MEM=0: FETCH/MREAD/MWRITE each take exactly 1 cycle.
//    Cycle counts: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//  - mem_ready outside FETCH/MREAD/MWRITE is ignored.
//  - mem_write and mem_read are never both 1. reg_write and mem_write are never both 1.
//  - rst mid-instruction aborts it and suppresses any pending write; after release,
//    the first state is FETCH.
// TESTING
//  1. rst=1 -> all outputs 0, state=0.
//     Release with mem_ready=1, opcode=100011 -> states 0,1,2,3,4,0.
//     reg_write=1 and mem_to_reg=1 only in state 4.
//  2. sw (101011) with mem_ready low 3 cycles in MWRITE -> state 5 held 4 cycles.
//     mem_write=1 throughout; exit to FETCH the cycle after mem_ready=1.
//  3. R-type 000000 -> 0,1,6,7,0; alu_op=10 in 6; reg_dst=1 and reg_write=1 in 7.
//     beq 000100 -> 0,1,8,0 with pc_write_cond=1 and alu_op=01 in 8.
//  4. opcode=111111 -> illegal_op pulses 1 cycle in DECODE, next state 0, no writes.
//     With ENABLE_J=0, opcode 000010 behaves the same way.
//  5. FETCH with mem_ready=0 for 2 cycles -> ir_write=pc_write=0 both cycles.
//     On mem_ready=1: ir_write=pc_write=1 for exactly 1 cycle.
//  6. Assert rst during MREAD -> outputs 0 immediately; no reg_write.
//     After release, state=0; then opcode=001000 -> 0,1,10,11,0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller-to-datapath control bundle
//
// Purpose: groups the opcode/memory-ready inputs and every datapath control
// output of the multi-cycle MIPS controller into one bundle.
// Ports (signals):
//   opcode, mem_ready           datapath -> controller
//   pc_write .. pc_source       controller -> datapath enables and mux selects
//   illegal_op, state           controller status / debug
// Modports: master = controller side, slave = datapath side.
interface multicycle_control_if #(
   parameter int ALU_OP_W = 2
);
   logic [5:0]          opcode;
   logic                mem_ready;
   logic                pc_write;
   logic                pc_write_cond;
   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                reg_dst;
   logic                mem_to_reg;
   logic                reg_write;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [ALU_OP_W-1:0] alu_op;
   logic [1:0]          pc_source;
   logic                illegal_op;
   logic [3:0]          state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM
//
// Purpose: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
// the datapath enables and mux selects each cycle. FETCH, MREAD and MWRITE
// wait on mem_ready when WAIT_MEM is set.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; forces all outputs to 0 while high
//   bus  control bundle (master side): opcode/mem_ready in, controls/state out
module multicycle_control #(
   parameter int ALU_OP_W    = 2,
   parameter int WAIT_MEM    = 1,
   parameter int ENABLE_J    = 1,
   parameter int ENABLE_ADDI = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_control_if.master  bus
);
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MADDR  = 4'd2;
   localparam logic [3:0] S_MREAD  = 4'd3;
   localparam logic [3:0] S_MWB    = 4'd4;
   localparam logic [3:0] S_MWRITE = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [3:0] S_AEXEC  = 4'd10;
   localparam logic [3:0] S_AWB    = 4'd11;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   logic [3:0]          state;
   logic [3:0]          state_nx;
   logic [5:0]          op_q;
   logic                mem_rdy;
   logic                illegal;
   logic [ALU_OP_W-1:0] alu_op_v;

   // Without memory waits every memory access completes in its first cycle.
   assign mem_rdy = (WAIT_MEM == 0) ? 1'b1 : bus.mem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         op_q  <= '0;
      end else begin
         state <= state_nx;
         // MADDR must pick lw/sw from the opcode seen in DECODE, not a later IR value.
         if (state == S_DECODE)
            op_q <= bus.opcode;
      end
   end

   always_comb begin
      state_nx = S_FETCH;
      illegal  = 1'b0;
      case (state)
         S_FETCH:  state_nx = mem_rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_R:         state_nx = S_EXEC;
               OP_LW, OP_SW: state_nx = S_MADDR;
               OP_BEQ:       state_nx = S_BRANCH;
               OP_J:         if (ENABLE_J != 0) state_nx = S_JUMP;
                             else illegal = 1'b1;
               OP_ADDI:      if (ENABLE_ADDI != 0) state_nx = S_AEXEC;
                             else illegal = 1'b1;
               default:      illegal = 1'b1;
            endcase
         end
         S_MADDR:  state_nx = (op_q == OP_LW) ? S_MREAD : S_MWRITE;
         S_MREAD:  state_nx = mem_rdy ? S_MWB : S_MREAD;
         S_MWRITE: state_nx = mem_rdy ? S_FETCH : S_MWRITE;
         S_EXEC:   state_nx = S_RWB;
         S_AEXEC:  state_nx = S_AWB;
         default:  state_nx = S_FETCH;
      endcase
   end

   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'd0;
      bus.pc_source     = 2'd0;
      bus.illegal_op    = 1'b0;
      alu_op_v          = '0;
      // Reset overrides decode so no write can escape while rst is high.
      if (!rst) begin
         case (state)
            S_FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'd1;
               bus.ir_write  = mem_rdy;
               bus.pc_write  = mem_rdy;
            end
            S_DECODE: begin
               bus.alu_src_b  = 2'd3;
               bus.illegal_op = illegal;
            end
            S_MADDR, S_AEXEC: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'd2;
            end
            S_MREAD: begin
               bus.mem_read = 1'b1;
               bus.i_or_d   = 1'b1;
            end
            S_MWB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            S_MWRITE: begin
               bus.mem_write = 1'b1;
               bus.i_or_d    = 1'b1;
            end
            S_EXEC: begin
               bus.alu_src_a = 1'b1;
               alu_op_v[1:0] = 2'b10;
            end
            S_RWB: begin
               bus.reg_write = 1'b1;
               bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               bus.alu_src_a     = 1'b1;
               alu_op_v[1:0]     = 2'b01;
               bus.pc_write_cond = 1'b1;
               bus.pc_source     = 2'd1;
            end
            S_JUMP: begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'd2;
            end
            S_AWB:   bus.reg_write = 1'b1;
            default: ;
         endcase
      end
      bus.alu_op = alu_op_v;
   end

   assign bus.state = state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
   logic clk = 1'b0;
   logic rst1, rst2;
   int   errors = 0;
   int   checks = 0;
   bit   done1 = 0, done2 = 0;

   always #5 clk = ~clk;

   typedef struct packed {
      logic        mr;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [16:0] outs;
   } cyc_t;

   cyc_t q1[$];
   cyc_t q2[$];

   multicycle_control_if #(.ALU_OP_W(2)) if1 ();
   multicycle_control_if #(.ALU_OP_W(3)) if2 ();

   multicycle_control #(.ALU_OP_W(2), .WAIT_MEM(1), .ENABLE_J(1), .ENABLE_ADDI(1))
      u_dut1 (.clk(clk), .rst(rst1), .bus(if1.master));
   multicycle_control #(.ALU_OP_W(3), .WAIT_MEM(0), .ENABLE_J(0), .ENABLE_ADDI(0))
      u_dut2 (.clk(clk), .rst(rst2), .bus(if2.master));

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
   localparam logic [5:0] BAD = 6'b111111;

   // Expected control word for a state; mr is the effective memory-ready in FETCH.
   // Order: pw pwc iod mrd mwr irw rd m2r rw asa asb[2] aop[2] psrc[2] ill
   function automatic logic [16:0] exp_outs(input int st, input bit mr);
      logic pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa} = '0;
      asb = 0; aop = 0; psrc = 0;
      case (st)
         0:  begin mrd = 1; asb = 1; irw = mr; pw = mr; end
         1:  asb = 3;
         2:  begin asa = 1; asb = 2; end
         3:  begin mrd = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iod = 1; end
         6:  begin asa = 1; aop = 2; end
         7:  begin rw = 1; rd = 1; end
         8:  begin asa = 1; aop = 1; pwc = 1; psrc = 1; end
         9:  begin pw = 1; psrc = 2; end
         10: begin asa = 1; asb = 2; end
         11: rw = 1;
         default: ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, psrc, 1'b0};
   endfunction

   function automatic cyc_t mk(input logic mr, input logic [5:0] op, input int st,
                               input logic [16:0] outs);
      cyc_t c;
      c.mr = mr; c.op = op; c.st = 4'(st); c.outs = outs;
      return c;
   endfunction

   // Cycle-by-cycle plan of one instruction: the state path is chosen from the
   // instruction class, memory stalls are inserted where a wait is allowed.
   function automatic void plan(input logic [5:0] op, input int fw, input int mw,
                                input bit wm, input bit ej, input bit ea,
                                output cyc_t arr [32], output int n);
      int path [4];
      int plen;
      bit legal;
      n = 0;
      for (int k = 0; k < 32; k++) arr[k] = '0;
      if (wm) for (int k = 0; k < fw; k++) begin
         arr[n] = mk(1'b0, 6'($urandom), 0, exp_outs(0, 0)); n++;
      end
      arr[n] = mk(wm, 6'($urandom), 0, exp_outs(0, 1)); n++;
      plen = 0;
      legal = 1;
      case (op)
         LW:      begin path[0] = 2; path[1] = 3; path[2] = 4; plen = 3; end
         SW:      begin path[0] = 2; path[1] = 5; plen = 2; end
         RT:      begin path[0] = 6; path[1] = 7; plen = 2; end
         BEQ:     begin path[0] = 8; plen = 1; end
         JMP:     if (ej) begin path[0] = 9; plen = 1; end else legal = 0;
         ADDI:    if (ea) begin path[0] = 10; path[1] = 11; plen = 2; end else legal = 0;
         default: legal = 0;
      endcase
      arr[n] = mk(1'($urandom), op, 1, exp_outs(1, 0) | {16'd0, !legal}); n++;
      for (int p = 0; p < plen; p++) begin
         if (path[p] == 3 || path[p] == 5) begin
            if (wm) for (int k = 0; k < mw; k++) begin
               arr[n] = mk(1'b0, 6'($urandom), path[p], exp_outs(path[p], 0)); n++;
            end
            arr[n] = mk(wm, 6'($urandom), path[p], exp_outs(path[p], 0)); n++;
         end else begin
            arr[n] = mk(1'($urandom), 6'($urandom), path[p], exp_outs(path[p], 0)); n++;
         end
      end
   endfunction

   task automatic drive1(input logic [5:0] op, input int fw, input int mw, input int stop_at);
      cyc_t arr [32];
      int n;
      plan(op, fw, mw, 1, 1, 1, arr, n);
      if (stop_at >= 0 && stop_at < n) n = stop_at;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rst1 = 0; if1.mem_ready = arr[i].mr; if1.opcode = arr[i].op;
         q1.push_back(arr[i]);
      end
   endtask

   task automatic reset1(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         rst1 = 1; if1.mem_ready = 1'($urandom); if1.opcode = 6'($urandom);
         q1.push_back(mk(if1.mem_ready, if1.opcode, 0, 17'd0));
      end
   endtask

   task automatic drive2(input logic [5:0] op);
      cyc_t arr [32];
      int n;
      plan(op, 0, 0, 0, 0, 0, arr, n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rst2 = 0; if2.mem_ready = arr[i].mr; if2.opcode = arr[i].op;
         q2.push_back(arr[i]);
      end
   endtask

   initial begin
      logic [5:0] ops [8];
      ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
      ops[4] = JMP; ops[5] = ADDI; ops[6] = BAD; ops[7] = 6'b010101;
      rst1 = 1; if1.mem_ready = 0; if1.opcode = 0;
      reset1(3);
      drive1(LW, 0, 0, -1);
      drive1(SW, 0, 3, -1);
      drive1(RT, 2, 0, -1);
      drive1(BEQ, 0, 0, -1);
      drive1(BAD, 0, 0, -1);
      drive1(JMP, 1, 0, -1);
      for (int t = 0; t < 40; t++)
         drive1(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), -1);
      drive1(LW, 0, 3, 4);          // stop in the first MREAD cycle
      reset1(2);
      drive1(ADDI, 0, 0, -1);
      done1 = 1;
   end

   initial begin
      rst2 = 1; if2.mem_ready = 0; if2.opcode = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         q2.push_back(mk(1'b0, 6'd0, 0, 17'd0));
      end
      drive2(LW); drive2(SW); drive2(RT); drive2(BEQ);
      drive2(JMP); drive2(ADDI); drive2(BAD); drive2(LW);
      done2 = 1;
   end

   always @(negedge clk) begin
      cyc_t e;
      logic [16:0] act;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         act = {if1.pc_write, if1.pc_write_cond, if1.i_or_d, if1.mem_read, if1.mem_write,
                if1.ir_write, if1.reg_dst, if1.mem_to_reg, if1.reg_write, if1.alu_src_a,
                if1.alu_src_b, if1.alu_op, if1.pc_source, if1.illegal_op};
         checks += 2;
         if (if1.state !== e.st) begin
            errors++;
            $display("FAIL dut1_state t=%0t actual=%0d required=%0d", $time, if1.state, e.st);
         end
         if (act !== e.outs) begin
            errors++;
            $display("FAIL dut1_outs t=%0t state=%0d actual=%b required=%b",
                     $time, e.st, act, e.outs);
         end
      end
      if (q2.size() > 0) begin
         e = q2.pop_front();
         act = {if2.pc_write, if2.pc_write_cond, if2.i_or_d, if2.mem_read, if2.mem_write,
                if2.ir_write, if2.reg_dst, if2.mem_to_reg, if2.reg_write, if2.alu_src_a,
                if2.alu_src_b, if2.alu_op[1:0], if2.pc_source, if2.illegal_op};
         checks += 3;
         if (if2.state !== e.st) begin
            errors++;
            $display("FAIL dut2_state t=%0t actual=%0d required=%0d", $time, if2.state, e.st);
         end
         if (act !== e.outs) begin
            errors++;
            $display("FAIL dut2_outs t=%0t state=%0d actual=%b required=%b",
                     $time, e.st, act, e.outs);
         end
         if (if2.alu_op[2] !== 1'b0) begin
            errors++;
            $display("FAIL dut2_alu_op_msb t=%0t actual=%b required=0", $time, if2.alu_op[2]);
         end
      end
   end

   initial begin
      int budget;
      budget = 0;
      while (!(done1 && done2) && budget < 20000) begin
         @(posedge clk);
         budget++;
      end
      repeat (3) @(posedge clk);
      checks++;
      if (!(done1 && done2) || q1.size() != 0 || q2.size() != 0) begin
         errors++;
         $display("FAIL drain done1=%0d done2=%0d q1=%0d q2=%0d required all done and empty",
                  done1, done2, q1.size(), q2.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
